vga_timing_ctrl: RTL
====================

Name: vga_timing_ctrl

Overview:
- Sequences the VGA display pipeline: divides the system clock to a pixel enable, runs horizontal and vertical segment state machines, and emits registered sync, data-enable and pixel coordinates.
- Pixel/colour generators consume `x`, `y`, `de` and `pix_ce`.
- A `run` handshake starts scan-out and stops it cleanly at the next frame boundary.

Parameters:
- CLK_DIV, 2, system clocks per pixel (≥1); 2 gives 25 MHz from 50 MHz
- H_SYNC, 96, hsync width in pixels
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vsync width in lines
- V_BACK, 33, vertical back porch
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch
- SYNC_POL, 1, active level of hsync/vsync

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  request continuous scan-out; sampled on pix_ce
- pix_ce  out  1  one-clk pixel enable every CLK_DIV clocks
- hsync  out  1  horizontal sync, level SYNC_POL when active
- vsync  out  1  vertical sync, level SYNC_POL when active
- de  out  1  visible-region data enable
- x  out  10  visible column 0..H_ACTIVE-1, else 0
- y  out  10  visible row 0..V_ACTIVE-1, else 0
- line_start  out  1  high for the pixel period where h=0
- frame_start  out  1  high for the pixel period where h=0, v=0
- busy  out  1  frame in progress

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: `pix_ce`=0, divider=0, state IDLE, h=v=0, `hsync`=`vsync`=~SYNC_POL, `de`=0, `x`=`y`=0, `line_start`=`frame_start`=0, `busy`=0.
- Divider:
  - counts 0..CLK_DIV-1 continuously after reset;
  - `pix_ce` is registered and high exactly when the divider wraps;
  - with CLK_DIV=1, `pix_ce` is 1 from the first clk after reset release.
- State updates: all timing state and outputs update only on clk edges where `pix_ce`=1. Outputs are registered and hold for the full pixel period (CLK_DIV clocks).
- Totals: H_TOTAL = sum of the H segments (800); V_TOTAL = sum of the V segments (525). Counters h and v are 10 bits; 1024 is an elaboration-time check limit.
- Horizontal FSM:
  - H_SYNC→H_BACK→H_ACTIVE→H_FRONT→H_SYNC, each state lasting its segment length in pixels;
  - the segment down-counter reloads on every transition.
- Vertical FSM:
  - V_SYNC→V_BACK→V_ACTIVE→V_FRONT, same structure;
  - advances one line only when h wraps H_TOTAL-1→0.
- Top FSM: IDLE / SCAN.
  - IDLE with `run`=1 at a `pix_ce` edge: enter SCAN at h=0, v=0; `frame_start`=`line_start`=1 and `busy`=1 on that edge.
  - SCAN, end of frame (h=H_TOTAL-1, v=V_TOTAL-1): if `run`=1, wrap to (0,0) with `frame_start`; else enter IDLE with reset-value outputs.
  - `run` deasserted mid-frame has no effect until the end of the frame. `run` changes between `pix_ce` edges are ignored.
- Output decode, aligned to the same registered (h,v):
  - `hsync` active iff h<H_SYNC;
  - `vsync` active iff v<V_SYNC;
  - `de` iff the H FSM is in H_ACTIVE and the V FSM is in V_ACTIVE;
  - `x` = h−(H_SYNC+H_BACK) when `de`, else 0;
  - `y` = v−(V_SYNC+V_BACK) when the V FSM is in V_ACTIVE, else 0.
- Reset mid-operation: all outputs take reset values immediately (asynchronously). Scan-out resumes only via a fresh `run` handshake after release.

Optional Feature:
- VGA_FRAME_CNT_EN defined: adds output `frame_cnt` [15:0].
  - Reset 0; increments on every edge that asserts `frame_start`.
  - Wraps 0xFFFF→0; holds its value while IDLE.
- Undefined: the port and counter are absent.

Decomposition:
- Package `vga_pkg` holds:
  - the default timing constants (640x480@60 values above);
  - the derived H_TOTAL/V_TOTAL functions;
  - enum typedef `seg_t` {SYNC, BACK, ACTIVE, FRONT};
  - enum typedef `top_t` {IDLE, SCAN}.
- One sub-module, `vga_seg_counter`:
  - parameterised by the four segment lengths, with an advance-enable input;
  - outputs position, `seg_t` state and a wrap flag;
  - instantiated twice (horizontal enabled by `pix_ce`, vertical by horizontal wrap).

Test Plan:
- Reset check: hold `rst_n`=0 with `run`=1 → `hsync`=`vsync`=0, `de`=0, `busy`=0; release, CLK_DIV=2 → `pix_ce` toggles 1-of-2 clocks.
- First frame, defaults, CLK_DIV=2, `run`=1:
  - `frame_start` high for 2 clks;
  - `hsync`=1 for exactly 192 clks per line; line period 1600 clks;
  - `vsync`=1 for 3200 clks.
- Visible region, same run:
  - first `de`=1 at h=144, v=35 with `x`=0, `y`=0;
  - last `de` at h=783, v=514 with `x`=639, `y`=479;
  - 307200 `de` pixels per frame.
- Stop handshake:
  - drop `run` at v=100 → frame completes; after h=799, v=524 the block enters IDLE and `busy`=0;
  - reassert `run` → new `frame_start` on the next `pix_ce`.
- Reset mid-frame at h=500, v=200 → outputs reset asynchronously, without waiting for a clk edge; no `frame_start` until `run` is sampled after release.
- VGA_FRAME_CNT_EN build, reduced timing (all segments 2, CLK_DIV=1): 5 consecutive frames → `frame_cnt`=5; preset to 0xFFFF → next frame gives 0.

Source files
------------

// File: rtl/vga_timing_ctrl_pkg.sv
// vga_pkg: default 640x480@60 timing, segment/top state types, debug
// snapshot struct and the line/frame total helpers shared by the VGA timing
// controller files.
package vga_pkg;

   localparam int DEF_CLK_DIV  = 2;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 10;
   localparam bit DEF_SYNC_POL = 1'b1;

   // Position counters are 10 bits wide, so a line or frame may not exceed this.
   localparam int CNT_W     = 10;
   localparam int CNT_LIMIT = 1024;

   typedef enum logic [1:0] {
      SYNC   = 2'd0,
      BACK   = 2'd1,
      ACTIVE = 2'd2,
      FRONT  = 2'd3
   } seg_t;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } top_t;

   // Snapshot of every state machine in the block, for checkers and debug.
   typedef struct packed {
      top_t             top;
      seg_t             hseg;
      seg_t             vseg;
      logic [CNT_W-1:0] h;
      logic [CNT_W-1:0] v;
   } vga_dbg_t;

   function automatic int h_total(input int s, input int b, input int a, input int f);
      return s + b + a + f;
   endfunction

   function automatic int v_total(input int s, input int b, input int a, input int f);
      return s + b + a + f;
   endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// vga_timing_ctrl_if: run request plus all timing outputs of the VGA timing
// controller. The master modport is the controller side, the slave modport is
// the pixel/colour generator side. frame_cnt exists only when
// VGA_FRAME_CNT_EN is defined.
//
// Handshake: run is a level request, sampled only on pix_ce edges. busy is
// the acknowledge: it rises on the pix_ce edge that accepts run (together with
// frame_start) and falls only on the pix_ce edge that ends a frame while run
// is low. Dropping run mid-frame never truncates a frame.
interface vga_timing_ctrl_if;
   import vga_pkg::*;

   logic             run;
   logic             pix_ce;
   logic             hsync;
   logic             vsync;
   logic             de;
   logic [CNT_W-1:0] x;
   logic [CNT_W-1:0] y;
   logic             line_start;
   logic             frame_start;
   logic             busy;
`ifdef VGA_FRAME_CNT_EN
   logic [15:0]      frame_cnt;
`endif
   vga_dbg_t         dbg;

   modport master (
      input  run,
      output pix_ce, hsync, vsync, de, x, y, line_start, frame_start, busy,
`ifdef VGA_FRAME_CNT_EN
      output frame_cnt,
`endif
      output dbg
   );

   modport slave (
      output run,
      input  pix_ce, hsync, vsync, de, x, y, line_start, frame_start, busy,
`ifdef VGA_FRAME_CNT_EN
      input  frame_cnt,
`endif
      input  dbg
   );

endinterface

// File: rtl/vga_timing_ctrl_seg_counter.sv
// vga_seg_counter: position counter walking SYNC->BACK->ACTIVE->FRONT and back
// to SYNC. A per-segment down-counter reloads on every segment change. Besides
// the registered position/segment it exposes the values the next advance will
// produce, so the parent can register decoded outputs aligned to them.
module vga_seg_counter
   import vga_pkg::*;
#(
   parameter int SYNC_LEN   = 2,
   parameter int BACK_LEN   = 2,
   parameter int ACTIVE_LEN = 2,
   parameter int FRONT_LEN  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             adv,
   output logic [CNT_W-1:0] pos,
   output logic [CNT_W-1:0] pos_nxt,
   output seg_t             seg,
   output seg_t             seg_nxt,
   output logic             wrap
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             last;

   function automatic seg_t seg_succ(input seg_t s);
      case (s)
         SYNC:    return BACK;
         BACK:    return ACTIVE;
         ACTIVE:  return FRONT;
         default: return SYNC;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] seg_reload(input seg_t s);
      case (s)
         SYNC:    return CNT_W'(SYNC_LEN - 1);
         BACK:    return CNT_W'(BACK_LEN - 1);
         ACTIVE:  return CNT_W'(ACTIVE_LEN - 1);
         default: return CNT_W'(FRONT_LEN - 1);
      endcase
   endfunction

   assign last = (seg == FRONT) && (cnt == '0);
   assign wrap = adv && last;

   // Next position, segment and remaining count for the current advance.
   always_comb begin
      pos_nxt = pos;
      seg_nxt = seg;
      cnt_nxt = cnt;
      if (adv) begin
         pos_nxt = last ? '0 : pos + 1'b1;
         if (cnt == '0) begin
            seg_nxt = seg_succ(seg);
            cnt_nxt = seg_reload(seg_succ(seg));
         end else begin
            cnt_nxt = cnt - 1'b1;
         end
      end
   end

   // Counter state; reset parks at the first pixel of SYNC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos <= '0;
         seg <= SYNC;
         cnt <= CNT_W'(SYNC_LEN - 1);
      end else begin
         pos <= pos_nxt;
         seg <= seg_nxt;
         cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA scan-out sequencer. Divides clk down to a one-clock
// pix_ce, runs horizontal and vertical segment counters and an IDLE/SCAN top
// FSM, and registers sync, data-enable, coordinates and start strobes so they
// hold for a full pixel period.
// Optional build macro VGA_FRAME_CNT_EN adds a 16-bit frame_cnt output.
module vga_timing_ctrl
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BACK   = DEF_H_BACK,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FRONT  = DEF_H_FRONT,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BACK   = DEF_V_BACK,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FRONT  = DEF_V_FRONT,
   parameter bit SYNC_POL = DEF_SYNC_POL
) (
   input  logic              clk,
   input  logic              rst_n,
   vga_timing_ctrl_if.master bus
);

   localparam int H_TOTAL = h_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
   localparam int V_TOTAL = v_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] X_OFS      = CNT_W'(H_SYNC + H_BACK);
   localparam logic [CNT_W-1:0] Y_OFS      = CNT_W'(V_SYNC + V_BACK);

   if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_ctrl: CLK_DIV must be at least 1");
   end
   if (H_TOTAL > CNT_LIMIT) begin : g_bad_h
      $error("vga_timing_ctrl: horizontal total exceeds 10-bit counter");
   end
   if (V_TOTAL > CNT_LIMIT) begin : g_bad_v
      $error("vga_timing_ctrl: vertical total exceeds 10-bit counter");
   end

   logic [DIV_W-1:0] div_q;
   logic             div_wrap;
   logic             pix_ce_q;

   top_t             state_q;
   top_t             state_nxt;

   logic             h_adv;
   logic             h_wrap;
   logic             v_wrap;
   logic [CNT_W-1:0] h_q, h_nxt, v_q, v_nxt;
   seg_t             hseg_q, hseg_nxt, vseg_q, vseg_nxt;

   logic             hsync_d, vsync_d, de_d, ls_d, fs_d;
   logic [CNT_W-1:0] x_d, y_d;
   logic             hsync_q, vsync_q, de_q, ls_q, fs_q;
   logic [CNT_W-1:0] x_q, y_q;

   assign div_wrap = (div_q == DIV_W'(CLK_DIV - 1));

   // Free-running pixel divider; pix_ce is registered on the divider wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q    <= '0;
         pix_ce_q <= 1'b0;
      end else begin
         div_q    <= div_wrap ? '0 : div_q + 1'b1;
         pix_ce_q <= div_wrap;
      end
   end

   // Counters sit at (0,0) while idle, so a new frame always starts there.
   assign h_adv = pix_ce_q && (state_q == SCAN);

   vga_seg_counter #(
      .SYNC_LEN   (H_SYNC),
      .BACK_LEN   (H_BACK),
      .ACTIVE_LEN (H_ACTIVE),
      .FRONT_LEN  (H_FRONT)
   ) u_h_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .adv     (h_adv),
      .pos     (h_q),
      .pos_nxt (h_nxt),
      .seg     (hseg_q),
      .seg_nxt (hseg_nxt),
      .wrap    (h_wrap)
   );

   vga_seg_counter #(
      .SYNC_LEN   (V_SYNC),
      .BACK_LEN   (V_BACK),
      .ACTIVE_LEN (V_ACTIVE),
      .FRONT_LEN  (V_FRONT)
   ) u_v_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .adv     (h_wrap),
      .pos     (v_q),
      .pos_nxt (v_nxt),
      .seg     (vseg_q),
      .seg_nxt (vseg_nxt),
      .wrap    (v_wrap)
   );

   // Top FSM register; only pixel-enable edges may change it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else if (pix_ce_q) begin
         state_q <= state_nxt;
      end
   end

   // Top FSM next state: start on run, stop only at the end of a frame.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (bus.run) state_nxt = SCAN;
         SCAN:    if (h_wrap && v_wrap && !bus.run) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Decode outputs from the position the counters move to on this edge.
   always_comb begin
      hsync_d = ~SYNC_POL;
      vsync_d = ~SYNC_POL;
      de_d    = 1'b0;
      x_d     = '0;
      y_d     = '0;
      ls_d    = 1'b0;
      fs_d    = 1'b0;
      if (state_nxt == SCAN) begin
         if (h_nxt < H_SYNC_END) hsync_d = SYNC_POL;
         if (v_nxt < V_SYNC_END) vsync_d = SYNC_POL;
         de_d = (hseg_nxt == ACTIVE) && (vseg_nxt == ACTIVE);
         if (de_d) x_d = h_nxt - X_OFS;
         if (vseg_nxt == ACTIVE) y_d = v_nxt - Y_OFS;
         ls_d = (h_nxt == '0);
         fs_d = ls_d && (v_nxt == '0);
      end
   end

   // Output registers, held for the whole pixel period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync_q <= ~SYNC_POL;
         vsync_q <= ~SYNC_POL;
         de_q    <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         ls_q    <= 1'b0;
         fs_q    <= 1'b0;
      end else if (pix_ce_q) begin
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         de_q    <= de_d;
         x_q     <= x_d;
         y_q     <= y_d;
         ls_q    <= ls_d;
         fs_q    <= fs_d;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   // Frame counter; idle never raises fs_d, so the count holds there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
      end else if (pix_ce_q && fs_d) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign bus.frame_cnt = frame_cnt_q;
`endif

   assign bus.pix_ce      = pix_ce_q;
   assign bus.hsync       = hsync_q;
   assign bus.vsync       = vsync_q;
   assign bus.de          = de_q;
   assign bus.x           = x_q;
   assign bus.y           = y_q;
   assign bus.line_start  = ls_q;
   assign bus.frame_start = fs_q;
   assign bus.busy        = (state_q == SCAN);
   assign bus.dbg         = '{top: state_q, hseg: hseg_q, vseg: vseg_q, h: h_q, v: v_q};

endmodule
